// File: rtl/reset_sequencer_if.sv
// Request/status bundle between a reset sequencer and the logic it serves.
// The sequencer drives the reset and status lines; the requester drives sw_rst_req.
`default_nettype none

interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] rst_n_out;
    logic                  busy;
    logic                  done;

    modport master (
        input  sw_rst_req,
        output rst_n_out,
        output busy,
        output done
    );

    modport slave (
        output sw_rst_req,
        input  rst_n_out,
        input  busy,
        input  done
    );
endinterface

`default_nettype wire

// File: rtl/reset_sequencer.sv
// Staged active-low reset generator: holds all stages low for HOLD_CYCLES, then
// releases them one by one STAGE_GAP cycles apart. Every output comes from a flop.
`default_nettype none

module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.master bus
);

    localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned STG_W   = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [STG_W-1:0]      stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    // State and output registers; rst forces every stage back into reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; stage_q is the index of the next stage to release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_n_d = rst_n_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
                    rst_n_d[0] = 1'b1;
                    cnt_d      = '0;
                    stage_d    = STG_W'(1);
                    if (NUM_STAGES == 1) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                        if (stage_q == STG_W'(i)) begin
                            rst_n_d[i] = 1'b1;
                        end
                    end
                    cnt_d   = '0;
                    stage_d = stage_q + STG_W'(1);
                    if (stage_q == STG_W'(NUM_STAGES - 1)) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                cnt_d = '0;
            end

            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                stage_d = '0;
                rst_n_d = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase

        // A software request restarts from any state; held high it pins the counter.
        if (bus.sw_rst_req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            stage_d = '0;
            rst_n_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    assign bus.rst_n_out = rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a default 4/16/4 instance and a 1/1/1
// instance share clk/rst/sw_rst_req and are checked against a release-time model.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(4)) if_a ();
    reset_sequencer_if #(.NUM_STAGES(1)) if_b ();

    reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(16), .STAGE_GAP(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.master)
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.master)
    );

    typedef struct packed {
        logic [3:0] rst_n;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   t           = -1;

    // t = edges since E0 (0 at E0); negative means the last edge was a reset.
    function automatic exp_t model(input int tt, input int n, input int h, input int g);
        exp_t e;
        e = '0;
        for (int k = 0; k < n; k++) begin
            if (tt >= 0 && tt >= h + k * g) e.rst_n[k] = 1'b1;
        end
        e.done = (tt >= 0) && (tt >= h + (n - 1) * g);
        e.busy = ~e.done;
        return e;
    endfunction

    task automatic step(input logic r, input logic s, output exp_t oa, output exp_t ob);
        @(negedge clk);
        rst             = r;
        if_a.sw_rst_req = s;
        if_b.sw_rst_req = s;
        @(posedge clk);
        if (r || s) t = -1;
        else        t = t + 1;
        sb_a.push_back(model(t, 4, 16, 4));
        sb_b.push_back(model(t, 1, 1, 1));
        #1;
        oa = {if_a.rst_n_out, if_a.busy, if_a.done};
        ob = {3'b000, if_b.rst_n_out, if_b.busy, if_b.done};
    endtask

    task automatic test_reset();
        exp_t oa, ob, ea, eb;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, oa, ob);
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got %b want %b", i, oa, ea);
            end
            vectors++;
            if (ob !== eb) begin
                miscompares++;
                $display("FAIL reset_min cyc%0d: got %b want %b", i, ob, eb);
            end
        end
    endtask

    task automatic test_power_on();
        exp_t oa, ob, ea;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, oa, ob);
            ea = sb_a.pop_front();
            void'(sb_b.pop_front());
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL power_on E%0d: got %b want %b", i, oa, ea);
            end
        end
    endtask

    task automatic test_sw_restart_in_run();
        exp_t oa, ob, ea;
        for (int i = 0; i < 33; i++) begin
            step(1'b0, (i == 0), oa, ob);
            ea = sb_a.pop_front();
            void'(sb_b.pop_front());
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL sw_in_run Er+%0d: got %b want %b", i, oa, ea);
            end
        end
    endtask

    task automatic test_sw_abort_mid_release();
        exp_t oa, ob, ea;
        step(1'b1, 1'b0, oa, ob);
        void'(sb_a.pop_front());
        void'(sb_b.pop_front());
        for (int i = 0; i <= 54; i++) begin
            step(1'b0, (i == 22), oa, ob);
            ea = sb_a.pop_front();
            void'(sb_b.pop_front());
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL sw_abort E%0d: got %b want %b", i, oa, ea);
            end
        end
    endtask

    task automatic test_rst_mid_sequence();
        exp_t oa, ob, ea;
        step(1'b1, 1'b0, oa, ob);
        void'(sb_a.pop_front());
        void'(sb_b.pop_front());
        for (int i = 0; i <= 50; i++) begin
            step((i == 18), 1'b0, oa, ob);
            ea = sb_a.pop_front();
            void'(sb_b.pop_front());
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL rst_mid E%0d: got %b want %b", i, oa, ea);
            end
        end
    endtask

    task automatic test_both_then_sw_held();
        exp_t oa, ob, ea;
        for (int i = 0; i < 3 + 10 + 32; i++) begin
            step((i < 3), (i < 13), oa, ob);
            ea = sb_a.pop_front();
            void'(sb_b.pop_front());
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL sw_held cyc%0d: got %b want %b", i, oa, ea);
            end
        end
    endtask

    task automatic test_min_config();
        exp_t oa, ob, eb;
        step(1'b1, 1'b0, oa, ob);
        void'(sb_a.pop_front());
        void'(sb_b.pop_front());
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i == 4), oa, ob);
            void'(sb_a.pop_front());
            eb = sb_b.pop_front();
            vectors++;
            if (ob !== eb) begin
                miscompares++;
                $display("FAIL min_cfg E%0d: got %b want %b", i, ob, eb);
            end
        end
    endtask

    task automatic test_random();
        exp_t oa, ob, ea, eb;
        logic r, s;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(63) == 0);
            s = ($urandom_range(31) == 0) || (i % 97 < 3 && i > 90);
            step(r, s, oa, ob);
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %b want %b", i, oa, ea);
            end
            vectors++;
            if (ob !== eb) begin
                miscompares++;
                $display("FAIL random_min cyc%0d: got %b want %b", i, ob, eb);
            end
        end
    endtask

    initial begin
        if_a.sw_rst_req = 1'b0;
        if_b.sw_rst_req = 1'b0;
        test_reset();
        test_power_on();
        test_sw_restart_in_run();
        test_sw_abort_mid_release();
        test_rst_mid_sequence();
        test_both_then_sw_held();
        test_min_config();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
